write_buffer: RTL and testbench

//  Output-side counterpart of the pixel read path. Collects filtered 24-bit

---
 rtl/write_buffer.sv | 137 +++++++++++++
 tb/tb_write_buffer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/write_buffer.sv
// Batch write buffer: gathers DEPTH filtered pixels, then drains them to SDRAM
// as single-word Avalon-MM writes at consecutive addresses, flagging batch and frame completion.
module write_buffer #(
  parameter int DEPTH        = 8,
  parameter int FRAME_PIXELS = 307200
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [23:0] pixel_data,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  output logic        master_write,
  output logic [31:0] master_address,
  output logic [31:0] master_writedata,
  input  logic        master_waitrequest,
  output logic        done_write8,
  output logic        frame_done
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int FRAME_W = $clog2(FRAME_PIXELS + 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    DONE
  } state_t;

  state_t state, state_next;

  logic [31:0]        addr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [FRAME_W-1:0] frame_cnt;
  logic [FRAME_W-1:0] frame_next;
  logic [23:0]        slot [DEPTH];

  logic start_ok;
  logic pixel_fire;
  logic word_fire;
  logic last_pixel;
  logic last_word;
  logic frame_end;

  // start only matters between frames; a batch in flight always completes
  assign start_ok   = start && ((state == IDLE) || (state == DONE));
  assign pixel_fire = pixel_valid && (state == FILL);
  assign last_pixel = pixel_fire && (wr_ptr == PTR_W'(DEPTH - 1));
  assign word_fire  = (state == WRITE) && !master_waitrequest;
  assign last_word  = word_fire && (rd_ptr == PTR_W'(DEPTH - 1));
  assign frame_next = frame_cnt + FRAME_W'(1);
  assign frame_end  = (frame_next == FRAME_W'(FRAME_PIXELS));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next       = state;
    pixel_ready      = 1'b0;
    master_write     = 1'b0;
    master_address   = 32'h0;
    master_writedata = 32'h0;

    case (state)
      IDLE: begin
        if (start) state_next = FILL;
      end
      FILL: begin
        pixel_ready = 1'b1;
        if (last_pixel) state_next = WRITE;
      end
      WRITE: begin
        master_write     = 1'b1;
        master_address   = addr;
        master_writedata = {8'h00, slot[rd_ptr]};
        if (last_word) state_next = frame_end ? DONE : FILL;
      end
      DONE: begin
        if (start) state_next = FILL;
      end
      default: state_next = IDLE;
    endcase
  end

  // Pointers, address and frame bookkeeping; status flags are registered pulses/levels
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      addr        <= 32'h0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      frame_cnt   <= '0;
      done_write8 <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      done_write8 <= last_word;

      if (start_ok) begin
        addr       <= base_addr;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        frame_cnt  <= '0;
        frame_done <= 1'b0;
      end

      if (pixel_fire) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end

      if (word_fire) begin
        addr      <= addr + 32'd4;
        rd_ptr    <= rd_ptr + PTR_W'(1);
        frame_cnt <= frame_next;
        if (last_word) begin
          rd_ptr <= '0;
          wr_ptr <= '0;
          if (frame_end) frame_done <= 1'b1;
        end
      end
    end
  end

  // Pixel storage needs no reset: pointers are cleared, so stale slots are never read
  always_ff @(posedge clk) begin
    if (pixel_fire) begin
      slot[wr_ptr] <= pixel_data;
    end
  end

endmodule

// File: tb/tb_write_buffer.sv
// Self-checking bench for write_buffer: a table of per-cycle vectors plus
// hand-written sequences for reset during a write and an Avalon stall.
module tb_write_buffer;

  logic        clk;
  logic        n_rst;
  logic        start;
  logic [31:0] base_addr;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic        pixel_ready;
  logic        master_write;
  logic [31:0] master_address;
  logic [31:0] master_writedata;
  logic        master_waitrequest;
  logic        done_write8;
  logic        frame_done;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic        rst_n;
    logic        start;
    logic [31:0] base;
    logic [23:0] pix;
    logic        valid;
    logic        wreq;
    logic        e_ready;
    logic        e_write;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic        e_done8;
    logic        e_fdone;
  } vec_t;

  vec_t vecs[$];

  write_buffer #(
    .DEPTH       (8),
    .FRAME_PIXELS(16)
  ) dut (
    .clk               (clk),
    .n_rst             (n_rst),
    .start             (start),
    .base_addr         (base_addr),
    .pixel_data        (pixel_data),
    .pixel_valid       (pixel_valid),
    .pixel_ready       (pixel_ready),
    .master_write      (master_write),
    .master_address    (master_address),
    .master_writedata  (master_writedata),
    .master_waitrequest(master_waitrequest),
    .done_write8       (done_write8),
    .frame_done        (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add_vec(input logic rst_n, input logic st, input logic [31:0] base,
                         input logic [23:0] pix, input logic valid, input logic wreq,
                         input logic e_ready, input logic e_write, input logic [31:0] e_addr,
                         input logic [31:0] e_data, input logic e_done8, input logic e_fdone);
    vec_t v;
    v.rst_n = rst_n; v.start = st; v.base = base; v.pix = pix; v.valid = valid; v.wreq = wreq;
    v.e_ready = e_ready; v.e_write = e_write; v.e_addr = e_addr; v.e_data = e_data;
    v.e_done8 = e_done8; v.e_fdone = e_fdone;
    vecs.push_back(v);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later, well clear of the rising edge
  task automatic apply_stimulus(input logic rst_n, input logic st, input logic [31:0] base,
                                input logic [23:0] pix, input logic valid, input logic wreq);
    @(negedge clk);
    n_rst              = rst_n;
    start              = st;
    base_addr          = base;
    pixel_data         = pix;
    pixel_valid        = valid;
    master_waitrequest = wreq;
    #1;
  endtask

  task automatic check_bit(input string tag, input int idx, input string what,
                           input logic got, input logic want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s[%0d] %s: got %b want %b", tag, idx, what, got, want);
    end
  endtask

  task automatic check_word(input string tag, input int idx, input string what,
                            input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s[%0d] %s: got %h want %h", tag, idx, what, got, want);
    end
  endtask

  task automatic check_output(input string tag, input int idx, input logic e_ready,
                              input logic e_write, input logic [31:0] e_addr,
                              input logic [31:0] e_data, input logic e_done8,
                              input logic e_fdone);
    check_bit(tag, idx, "pixel_ready", pixel_ready, e_ready);
    check_bit(tag, idx, "master_write", master_write, e_write);
    check_word(tag, idx, "master_address", master_address, e_addr);
    check_word(tag, idx, "master_writedata", master_writedata, e_data);
    check_bit(tag, idx, "done_write8", done_write8, e_done8);
    check_bit(tag, idx, "frame_done", frame_done, e_fdone);
  endtask

  initial begin
    int idx;
    n_cmp              = 0;
    n_fail             = 0;
    n_rst              = 1'b0;
    start              = 1'b0;
    base_addr          = 32'h0;
    pixel_data         = 24'h0;
    pixel_valid        = 1'b0;
    master_waitrequest = 1'b0;

    // Reset state
    add_vec(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    add_vec(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);

    // Batch at 0x1000, no stalls
    add_vec(1, 1, 32'h1000, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++)
      add_vec(1, 0, 0, 24'(k + 1), 1, 0,  1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++)
      add_vec(1, 0, 0, 0, 0, 0,  0, 1, 32'h1000 + 32'(4 * k), 32'(k + 1), 0, 0);
    add_vec(1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0);
    add_vec(1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);

    // Second batch with pixel_valid held during WRITE; completes the frame
    for (int k = 0; k < 8; k++)
      add_vec(1, 0, 0, 24'(k + 9), 1, 0,  1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++)
      add_vec(1, 0, 0, 24'hAA0000 + 24'(k), 1, 0,  0, 1, 32'h1020 + 32'(4 * k), 32'(k + 9), 0, 0);
    add_vec(1, 0, 0, 24'hAA0008, 1, 0,  0, 0, 0, 0, 1, 1);
    add_vec(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);

    // Restart from DONE at 0x2000; a start pulse during FILL must be ignored
    add_vec(1, 1, 32'h2000, 0, 0, 0,  0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 8; k++)
      add_vec(1, (k == 2), (k == 2) ? 32'hFFFF_FFF8 : 32'h0, 24'h101 + 24'(k), 1, 0,  1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++)
      add_vec(1, 0, 0, 0, 0, 0,  0, 1, 32'h2000 + 32'(4 * k), 32'h101 + 32'(k), 0, 0);
    add_vec(1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0);
    for (int k = 0; k < 8; k++)
      add_vec(1, 0, 0, 24'h201 + 24'(k), 1, 0,  1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++)
      add_vec(1, 0, 0, 0, 0, 0,  0, 1, 32'h2020 + 32'(4 * k), 32'h201 + 32'(k), 0, 0);
    add_vec(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1);

    // Address wrap from 0xFFFF_FFF8
    add_vec(1, 1, 32'hFFFF_FFF8, 0, 0, 0,  0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 8; k++)
      add_vec(1, 0, 0, 24'h301 + 24'(k), 1, 0,  1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++)
      add_vec(1, 0, 0, 0, 0, 0,  0, 1, 32'hFFFF_FFF8 + 32'(4 * k), 32'h301 + 32'(k), 0, 0);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].rst_n, vecs[i].start, vecs[i].base, vecs[i].pix,
                     vecs[i].valid, vecs[i].wreq);
      check_output("table", i, vecs[i].e_ready, vecs[i].e_write, vecs[i].e_addr,
                   vecs[i].e_data, vecs[i].e_done8, vecs[i].e_fdone);
    end

    // Reset asserted mid-WRITE: outputs clear immediately and stay idle without a start
    apply_stimulus(0, 0, 0, 0, 0, 0);
    check_output("rst_mid", 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k < 4; k++) begin
      apply_stimulus(1, 0, 0, 24'h55, 1, 0);
      check_output("rst_mid", k, 0, 0, 0, 0, 0, 0);
    end

    // Three-cycle stall on the second word: address/data held four cycles, nothing lost
    idx = 0;
    apply_stimulus(1, 1, 32'h1000, 0, 0, 0);
    check_output("stall", idx++, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      apply_stimulus(1, 0, 0, 24'(k + 1), 1, 0);
      check_output("stall", idx++, 1, 0, 0, 0, 0, 0);
    end
    apply_stimulus(1, 0, 0, 0, 0, 0);
    check_output("stall", idx++, 0, 1, 32'h1000, 32'h1, 0, 0);
    for (int s = 0; s < 4; s++) begin
      apply_stimulus(1, 0, 0, 0, 0, (s < 3));
      check_output("stall", idx++, 0, 1, 32'h1004, 32'h2, 0, 0);
    end
    for (int k = 2; k < 8; k++) begin
      apply_stimulus(1, 0, 0, 0, 0, 0);
      check_output("stall", idx++, 0, 1, 32'h1000 + 32'(4 * k), 32'(k + 1), 0, 0);
    end
    apply_stimulus(1, 0, 0, 0, 0, 0);
    check_output("stall", idx++, 1, 0, 0, 0, 1, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0);
    check_output("stall", idx++, 1, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
